// File: rtl/decode_queue_ctrl.sv
// decode_queue_ctrl: decode-queue occupancy, fetch gating and redirect flush/drain sequencer.
// Optional DEC_Q_CTRL_PERF_EN adds stall/flush/drop performance counters.
module decode_queue_ctrl #(
  parameter int DEC_Q_N    = 8,
  parameter int MICRO_Q_N  = 4,
  parameter int CNT_W      = $clog2(DEC_Q_N+1),
  parameter int ADDR_W     = 64,
  parameter int REFILL_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fet_inst_valid,
  input  logic [CNT_W-1:0]  fet_uop_cnt,
  input  logic              exe_stall,
  input  logic              redirect_req,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fet_accept,
  output logic              fet_stall,
  output logic              deq_stall,
  output logic              deq_flush,
  output logic              fet_pc_set,
  output logic [ADDR_W-1:0] fet_pc_next,
  output logic [CNT_W-1:0]  occupancy,
  output logic              head_valid
`ifdef DEC_Q_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;
  localparam logic [CNT_W:0] QN = (CNT_W+1)'(DEC_Q_N);
  state_e            state_q;
  logic [3:0]        drain_q;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] pc_q;
  logic              flush_q;
  logic              run, pop;
  logic [CNT_W:0]    room;
  assign run        = state_q == RUN;
  assign deq_stall  = exe_stall | ~run;
  assign head_valid = occ_q != '0;
  assign pop        = ~deq_stall & head_valid;
  // free space counting the slot the head pop releases this cycle
  assign room       = QN - {1'b0, occ_q} + (CNT_W+1)'(pop);
  assign fet_accept = run & fet_inst_valid & ~deq_stall & ~redirect_req & ({1'b0, fet_uop_cnt} <= room);
  assign fet_stall  = fet_inst_valid & ~fet_accept & run;
  assign occ_d      = (redirect_req | state_q == FLUSH) ? '0
                    : occ_q - CNT_W'(pop) + (fet_accept ? fet_uop_cnt : '0);
  assign occupancy   = occ_q;
  assign deq_flush   = flush_q;
  assign fet_pc_set  = flush_q;
  assign fet_pc_next = pc_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      drain_q <= '0;
      occ_q   <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      flush_q <= redirect_req;
      if (redirect_req) begin
        state_q <= FLUSH;
        pc_q    <= redirect_pc;
      end else if (state_q == FLUSH) begin
        state_q <= DRAIN;
        drain_q <= 4'(REFILL_LAT-1);
      end else if (state_q == DRAIN) begin
        if (drain_q == '0) state_q <= RUN;
        else drain_q <= drain_q - 4'd1;
      end
    end
  end
`ifdef DEC_Q_CTRL_PERF_EN
  logic [31:0] stall_q, flush_cnt_q, drop_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
      drop_q      <= '0;
    end else begin
      stall_q     <= stall_q + 32'(fet_stall);
      flush_cnt_q <= flush_cnt_q + 32'(redirect_req);
      drop_q      <= drop_q + 32'(fet_inst_valid & ~run);
    end
  end
  assign perf_stall_cyc = stall_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_drop_cnt  = drop_q;
`endif
  assert property (@(posedge clk) disable iff (!rstn) occ_q <= CNT_W'(DEC_Q_N));
  assert property (@(posedge clk) disable iff (!rstn) !fet_inst_valid || fet_uop_cnt <= CNT_W'(MICRO_Q_N));
endmodule

// File: tb/tb_decode_queue_ctrl.sv
// tb_decode_queue_ctrl: scoreboard bench; driver pushes expected outputs, negedge monitor compares.
module tb_decode_queue_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fet_inst_valid = 1'b0;
  logic [3:0]  fet_uop_cnt = '0;
  logic        exe_stall = 1'b0;
  logic        redirect_req = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fet_accept, fet_stall, deq_stall, deq_flush, fet_pc_set, head_valid;
  logic [63:0] fet_pc_next;
  logic [3:0]  occupancy;
`ifdef DEC_Q_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_drop_cnt;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {
    string       nm;
    logic        acc, fst, dst, fl;
    logic [63:0] pc;
    logic [3:0]  occ;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  decode_queue_ctrl dut (
    .clk(clk), .rstn(rstn), .fet_inst_valid(fet_inst_valid), .fet_uop_cnt(fet_uop_cnt),
    .exe_stall(exe_stall), .redirect_req(redirect_req), .redirect_pc(redirect_pc),
    .fet_accept(fet_accept), .fet_stall(fet_stall), .deq_stall(deq_stall), .deq_flush(deq_flush),
    .fet_pc_set(fet_pc_set), .fet_pc_next(fet_pc_next), .occupancy(occupancy), .head_valid(head_valid)
`ifdef DEC_Q_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );
  task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", nm, f, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "fet_accept", 64'(fet_accept), 64'(e.acc));
      chk(e.nm, "fet_stall", 64'(fet_stall), 64'(e.fst));
      chk(e.nm, "deq_stall", 64'(deq_stall), 64'(e.dst));
      chk(e.nm, "deq_flush", 64'(deq_flush), 64'(e.fl));
      chk(e.nm, "fet_pc_set", 64'(fet_pc_set), 64'(e.fl));
      chk(e.nm, "fet_pc_next", fet_pc_next, e.pc);
      chk(e.nm, "occupancy", 64'(occupancy), 64'(e.occ));
      chk(e.nm, "head_valid", 64'(head_valid), 64'(e.occ != 0));
    end
  end
  task automatic step(input string nm, input bit r, input bit v, input logic [3:0] c, input bit es,
                      input bit rr, input logic [63:0] rpc, input bit acc, input bit fst, input bit dst,
                      input bit fl, input logic [63:0] pc, input logic [3:0] occ);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = r; fet_inst_valid = v; fet_uop_cnt = c; exe_stall = es; redirect_req = rr; redirect_pc = rpc;
    e.nm = nm; e.acc = acc; e.fst = fst; e.dst = dst; e.fl = fl; e.pc = pc; e.occ = occ;
    q.push_back(e);
  endtask
  initial begin
    int ms, md, mo, room;
    logic [63:0] mpc;
    bit v, es, rr, pop, acc, dst, run;
    logic [3:0] c;
    logic [63:0] rpc;
    repeat (2) @(posedge clk);
    //    name          rstn v c es rr rpc        acc fst dst fl pc        occ
    step("rst",         0, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0);
    step("stall_blk",   1, 1, 4, 1, 0, 64'h0,    0, 1, 1, 0, 64'h0,    0);
    step("push4",       1, 1, 4, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0);
    step("push4b",      1, 1, 4, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    4);
    step("push2",       1, 1, 2, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    7);
    step("full_cnt1",   1, 1, 1, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    8);
    step("full_cnt2",   1, 1, 2, 0, 0, 64'h0,    0, 1, 0, 0, 64'h0,    8);
    step("hold_stall",  1, 1, 1, 1, 0, 64'h0,    0, 1, 1, 0, 64'h0,    7);
    step("refill",      1, 1, 2, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    7);
    step("zero_full",   1, 1, 0, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    8);
    step("redir",       1, 1, 1, 0, 1, 64'h1000, 0, 1, 0, 0, 64'h0,    7);
    step("flush",       1, 1, 1, 0, 0, 64'h0,    0, 0, 1, 1, 64'h1000, 0);
    step("drain1",      1, 1, 1, 0, 0, 64'h0,    0, 0, 1, 0, 64'h1000, 0);
    step("drain0",      1, 1, 1, 0, 0, 64'h0,    0, 0, 1, 0, 64'h1000, 0);
    step("resume",      1, 1, 3, 0, 0, 64'h0,    1, 0, 0, 0, 64'h1000, 0);
    step("pop_only",    1, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h1000, 3);
    step("redir_b",     1, 0, 0, 0, 1, 64'h3000, 0, 0, 0, 0, 64'h1000, 2);
    step("flush_b",     1, 0, 0, 0, 0, 64'h0,    0, 0, 1, 1, 64'h3000, 0);
    step("redir_drain", 1, 1, 1, 0, 1, 64'h2000, 0, 0, 1, 0, 64'h3000, 0);
    step("flush_c",     1, 0, 0, 0, 0, 64'h0,    0, 0, 1, 1, 64'h2000, 0);
    step("drain_c1",    1, 1, 2, 0, 0, 64'h0,    0, 0, 1, 0, 64'h2000, 0);
    step("drain_c0",    1, 1, 2, 0, 0, 64'h0,    0, 0, 1, 0, 64'h2000, 0);
    step("resume_c",    1, 1, 4, 0, 0, 64'h0,    1, 0, 0, 0, 64'h2000, 0);
    step("redir_pop",   1, 0, 0, 0, 1, 64'h4000, 0, 0, 0, 0, 64'h2000, 4);
    step("flush_d",     1, 0, 0, 0, 0, 64'h0,    0, 0, 1, 1, 64'h4000, 0);
    step("rst_drain",   0, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0);
    step("post_rst",    1, 1, 4, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0);
    step("push2_r",     1, 1, 2, 0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    4);
    step("occ5",        1, 0, 0, 1, 0, 64'h0,    0, 0, 1, 0, 64'h0,    5);
    step("rst_occ5",    0, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0);
    step("rel",         1, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0);
    ms = 0; md = 0; mo = 0; mpc = '0;
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(0, 3) != 0;
      c = 4'($urandom_range(0, 4));
      es = $urandom_range(0, 3) == 0;
      rr = $urandom_range(0, 31) == 0;
      rpc = {$urandom, $urandom};
      run = ms == 0;
      dst = es | !run;
      pop = !dst && mo != 0;
      room = 8 - mo + int'(pop);
      acc = run && v && !dst && !rr && int'(c) <= room;
      step("rand", 1, v, c, es, rr, rpc, acc, v && !acc && run, dst, ms == 1, mpc, 4'(mo));
      mo = (rr || ms == 1) ? 0 : mo - int'(pop) + (acc ? int'(c) : 0);
      if (rr) begin ms = 1; mpc = rpc; end
      else if (ms == 1) begin ms = 2; md = 1; end
      else if (ms == 2) begin
        if (md == 0) ms = 0;
        else md--;
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
